ram_readback_checker: RTL and testbench



---
 rtl/ram_readback_checker_if.sv | 28 ++
 rtl/ram_readback_checker.sv | 141 ++++++++++++++
 tb/tb_ram_readback_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_readback_checker_if.sv
// Bus between the S-box readback checker and the shared single-port RAM mux.
// The slave side is the checker; the master side is the RAM and its controller.
interface ram_readback_checker_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] ram_out;
    logic [ADDR_W-1:0] address;
    logic              write_enable;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   mismatch_count;
    logic [ADDR_W-1:0] first_bad_addr;
    logic [DATA_W-1:0] first_bad_data;

    modport master (
        output start, ram_out,
        input  address, write_enable, done, pass,
               mismatch_count, first_bad_addr, first_bad_data
    );

    modport slave (
        input  start, ram_out,
        output address, write_enable, done, pass,
               mismatch_count, first_bad_addr, first_bad_data
    );
endinterface

// File: rtl/ram_readback_checker.sv
// Sweeps every RAM address once, checks each word against the identity pattern S[i]=i
// and reports pass/fail, the mismatch count and the first failing location.
module ram_readback_checker #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ram_readback_checker_if.slave   io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [ADDR_W-1:0] PENULT_ADDR = LAST_ADDR - ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_address;
    logic [ADDR_W:0]     r_mismatch_count;
    logic [ADDR_W-1:0]   r_first_bad_addr;
    logic [DATA_W-1:0]   r_first_bad_data;
    logic                r_pass;

    // Tag pipeline: stage READ_LATENCY-1 names the address whose data is on ram_out now.
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [ADDR_W-1:0]       r_tag_addr [READ_LATENCY];

    logic              w_push;
    logic [ADDR_W-1:0] w_push_addr;
    logic              w_start_run;
    logic              w_finish;
    logic              w_done;
    logic [DATA_W-1:0] w_expected;
    logic              w_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start)              w_state_next = S_READ;
            S_READ:  if (r_address == PENULT_ADDR)  w_state_next = S_DRAIN;
            S_DRAIN: if (r_tag_valid == '0)         w_state_next = S_DONE;
            S_DONE:  if (!io_bus.start)             w_state_next = S_IDLE;
            default:                                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_addr = '0;
        w_start_run = 1'b0;
        w_finish    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_run = io_bus.start;
                w_push      = io_bus.start;
            end
            S_READ: begin
                w_push      = 1'b1;
                w_push_addr = r_address + ADDR_W'(1);
            end
            S_DRAIN: w_finish = (r_tag_valid == '0);
            S_DONE:  w_done   = 1'b1;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_valid[gi] <= 1'b0;
                    r_tag_addr[gi]  <= '0;
                end else if (gi == 0) begin
                    r_tag_valid[gi] <= w_push;
                    r_tag_addr[gi]  <= w_push_addr;
                end else begin
                    r_tag_valid[gi] <= r_tag_valid[(gi == 0) ? 0 : gi - 1];
                    r_tag_addr[gi]  <= r_tag_addr[(gi == 0) ? 0 : gi - 1];
                end
            end
        end

        // Expected word is the address truncated or zero-extended to the data width.
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_exp
            if (gi < ADDR_W) begin : g_bit
                assign w_expected[gi] = r_tag_addr[READ_LATENCY-1][gi];
            end else begin : g_zero
                assign w_expected[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_mismatch = r_tag_valid[READ_LATENCY-1] && (io_bus.ram_out != w_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address        <= '0;
            r_mismatch_count <= '0;
            r_first_bad_addr <= '0;
            r_first_bad_data <= '0;
            r_pass           <= 1'b0;
        end else begin
            if (w_push) begin
                r_address <= w_push_addr;
            end
            if (w_start_run) begin
                r_mismatch_count <= '0;
                r_first_bad_addr <= '0;
                r_first_bad_data <= '0;
                r_pass           <= 1'b0;
            end else if (w_mismatch) begin
                r_mismatch_count <= r_mismatch_count + (ADDR_W + 1)'(1);
                if (r_mismatch_count == '0) begin
                    r_first_bad_addr <= r_tag_addr[READ_LATENCY-1];
                    r_first_bad_data <= io_bus.ram_out;
                end
            end
            if (w_finish) begin
                r_pass <= (r_mismatch_count == '0);
            end
        end
    end

    assign io_bus.address        = r_address;
    assign io_bus.write_enable   = 1'b0;
    assign io_bus.done           = w_done;
    assign io_bus.pass           = r_pass;
    assign io_bus.mismatch_count = r_mismatch_count;
    assign io_bus.first_bad_addr = r_first_bad_addr;
    assign io_bus.first_bad_data = r_first_bad_data;
endmodule

// File: tb/tb_ram_readback_checker.sv
// Randomised readback runs on two checkers (read latency 1 and 2) sharing one RAM image,
// each compared against a whole-array reference of what the sweep should report.
module tb_ram_readback_checker;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    ram_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_b;

    // Latency 1: data for the driven address is visible in the same cycle.
    // Latency 2: one register between address and data.
    assign bus_a.start   = start;
    assign bus_b.start   = start;
    assign bus_a.ram_out = mem[bus_a.address];
    always @(posedge clk) rd_b <= mem[bus_b.address];
    assign bus_b.ram_out = rd_b;

    ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_a)
    );

    ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: scan the whole image for words that differ from their index.
    task automatic model(output int cnt, output int fa, output int fd);
        cnt = 0; fa = 0; fd = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] != DW'(i)) begin
                if (cnt == 0) begin
                    fa = i;
                    fd = int'(mem[i]);
                end
                cnt++;
            end
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
    endtask

    task automatic check_results(input string name, input int cnt, input int fa, input int fd);
        check_val({name, "/a_count"}, 32'(bus_a.mismatch_count), cnt);
        check_val({name, "/a_pass"},  32'(bus_a.pass), (cnt == 0) ? 1 : 0);
        check_val({name, "/a_faddr"}, 32'(bus_a.first_bad_addr), fa);
        check_val({name, "/a_fdata"}, 32'(bus_a.first_bad_data), fd);
        check_val({name, "/b_count"}, 32'(bus_b.mismatch_count), cnt);
        check_val({name, "/b_pass"},  32'(bus_b.pass), (cnt == 0) ? 1 : 0);
        check_val({name, "/b_faddr"}, 32'(bus_b.first_bad_addr), fa);
        check_val({name, "/b_fdata"}, 32'(bus_b.first_bad_data), fd);
    endtask

    task automatic do_run(input string name, input int drop_at, input bit hold_after);
        int c0, k, exp_addr, cnt, fa, fd;
        int done_a_at = -1;
        int done_b_at = -1;
        int seq_err   = 0;
        int we_err    = 0;
        model(cnt, fa, fd);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        for (int t = 0; t < 400 && (done_a_at < 0 || done_b_at < 0); t++) begin
            @(negedge clk);
            k = cyc - c0;
            if (drop_at >= 0 && k == drop_at) start = 1'b0;
            exp_addr = (k < N - 1) ? k : N - 1;
            if (bus_a.address !== AW'(exp_addr)) seq_err++;
            if (bus_b.address !== AW'(exp_addr)) seq_err++;
            if (bus_a.write_enable !== 1'b0 || bus_b.write_enable !== 1'b0) we_err++;
            if (done_a_at < 0 && bus_a.done === 1'b1) done_a_at = k;
            if (done_b_at < 0 && bus_b.done === 1'b1) done_b_at = k;
        end
        check_val({name, "/done_a_edge"}, done_a_at, N + 1);
        check_val({name, "/done_b_edge"}, done_b_at, N + 2);
        check_val({name, "/addr_seq_errs"}, seq_err, 0);
        check_val({name, "/we_errs"}, we_err, 0);
        check_results(name, cnt, fa, fd);
        if (hold_after) begin
            repeat (6) @(negedge clk);
            check_val({name, "/hold_done"}, {bus_a.done, bus_b.done}, 2'b11);
            check_val({name, "/hold_addr"}, {bus_a.address, bus_b.address}, {AW'(N - 1), AW'(N - 1)});
        end
        start = 1'b0;
        @(negedge clk);
        check_val({name, "/done_drop"}, {bus_a.done, bus_b.done}, 2'b00);
        check_results({name, "/kept"}, cnt, fa, fd);
        $display("run %-10s count=%0d first_addr=0x%0h first_data=0x%0h pass=%0d/%0d",
                 name, bus_a.mismatch_count, bus_a.first_bad_addr, bus_a.first_bad_data,
                 bus_a.pass, bus_b.pass);
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        int c0;
        bit hit = 1'b0;
        fill_identity();
        mem[8'h10] = 8'h55;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        for (int t = 0; t < 300 && !hit; t++) begin
            @(negedge clk);
            if (cyc - c0 == 8'h80) hit = 1'b1;
        end
        check_val("rst/reached", hit, 1);
        check_val("rst/addr_before", bus_a.address, 8'h80);
        check_val("rst/count_before", 32'(bus_a.mismatch_count), 1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_val("rst/a_outputs", {bus_a.address, bus_a.done, bus_a.pass, bus_a.mismatch_count,
                                    bus_a.first_bad_addr, bus_a.first_bad_data}, 0);
        check_val("rst/b_outputs", {bus_b.address, bus_b.done, bus_b.pass, bus_b.mismatch_count,
                                    bus_b.first_bad_addr, bus_b.first_bad_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst/idle_after", {bus_a.address, bus_a.done, bus_b.address, bus_b.done}, 0);
        $display("run reset     asserted at address 0x80, outputs cleared");
        fill_identity();
        do_run("post_rst", -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad;
        fill_identity();
        repeat (3) @(negedge clk);
        check_val("reset/a_outputs", {bus_a.address, bus_a.done, bus_a.pass, bus_a.mismatch_count,
                                      bus_a.first_bad_addr, bus_a.first_bad_data}, 0);
        check_val("reset/b_outputs", {bus_b.address, bus_b.done, bus_b.pass, bus_b.mismatch_count,
                                      bus_b.first_bad_addr, bus_b.first_bad_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_identity();
        do_run("clean", -1, 1'b1);

        fill_identity();
        mem[8'h37] = 8'hFF;
        do_run("single", -1, 1'b0);

        fill_identity();
        mem[8'h10] = 8'h00;
        mem[8'hFE] = 8'h01;
        do_run("double", -1, 1'b0);

        for (int i = 0; i < N; i++) mem[i] = '0;
        do_run("all_zero", -1, 1'b0);

        reset_mid_run();

        for (int r = 0; r < 4; r++) begin
            fill_identity();
            n_bad = $urandom_range(0, 6);
            for (int j = 0; j < n_bad; j++) mem[$urandom_range(0, N - 1)] = DW'($urandom);
            do_run($sformatf("rand%0d", r), (r == 2) ? int'($urandom_range(1, 200)) : -1, r[0]);
        end

        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        do_run("rand_full", -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
